mux_2x1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_2x1_rr_arbiter
// PURPOSE
//  Sequential controller for a 2:1 merge point in the NoC. Arbitrates two valid/ready input channels
//  (low = branch 0, high = branch 1) and drives the combinational 2x1 mux select and enable.
//  Registers the selected flit into a 1-entry output stage toward the downstream router/PE port.
//  Round-robin with bounded burst: a branch keeps the grant for up to MAX_BURST consecutive flits.
// PARAMETERS
//  DATA_WIDTH      32  flit width per branch
//  COMMAND_WIDTH   1   mux select width (1 = high branch, 0 = low branch)
//  MAX_BURST       4   max consecutive grants to one branch while the other requests (>=1)
//  CNT_WIDTH       3   burst counter width, must hold MAX_BURST ($clog2(MAX_BURST+1))
// PORTS
//  clk           in   1              clock, all state on posedge
//  rst           in   1              synchronous reset, active-high
//  i_en          in   1              arbiter enable; 0 freezes arbitration (output stage still drains)
//  i_valid       in   2              per-branch request; [0]=low, [1]=high
//  i_data_bus    in   2*DATA_WIDTH   {high, low} flits
//  o_ready       out  2              per-branch accept; flit taken when i_valid[k] & o_ready[k]
//  o_valid       out  1              output stage holds a flit
//  o_data_bus    out  DATA_WIDTH     registered flit, all-zero when o_valid=0
//  i_ready       in   1              downstream accept; transfer when o_valid & i_ready
//  o_mux_en      out  1              mux enable (combinational)
//  o_mux_cmd     out  COMMAND_WIDTH  mux select (combinational)
//  o_last_grant  out  1              branch that won the most recent transfer (0=low, 1=high)
// BEHAVIOUR
//  Reset: o_valid=0, o_data_bus=0, state=IDLE, burst_cnt=0, o_last_grant=1 (so low wins first).
//  load = i_en & (~o_valid | i_ready): output stage can accept this cycle (full-throughput pass-through).
//  o_ready[k] = load & grant[k]; at most one bit set; o_ready=2'b00 when i_en=0.
//  o_mux_en = load & |grant; o_mux_cmd = grant[1]; both 0 when nothing granted.
//  Latency: flit accepted in cycle N appears on o_data_bus/o_valid in N+1. 1 flit/cycle sustained.
//  Output stage: on load with a grant, capture the mux output and set o_valid=1; on o_valid&i_ready
//   without a new grant, clear o_valid and zero o_data_bus; else hold (stall-stable data).
//  FSM states: IDLE, HOLD_LO, HOLD_HI (encodings in shared header).
//   IDLE: none valid -> no grant. One valid -> grant it. Both -> grant ~o_last_grant.
//   HOLD_x: grant x if i_valid[x] and (burst_cnt<MAX_BURST or other branch idle); else grant other
//    if valid; else none -> IDLE.
//   State/burst_cnt/o_last_grant update only on an accepted flit (load & |grant).
//   Accepted flit on same branch: burst_cnt+1, saturating at MAX_BURST. Switch branch: burst_cnt=1.
//   Burst cap only applies while the other branch is requesting; a lone requester streams unlimited.
//  Simultaneous: switch and downstream drain in same cycle allowed; no bubble.
//  i_en low mid-burst: FSM, counter and pointer frozen; output stage still drains on i_ready.
//  rst mid-operation: in-flight output flit dropped; o_ready=0 in the reset cycle.
//  A branch dropping i_valid without a handshake is allowed (no lock held on it).
// STRUCTURE
//  Shared header mux_ctrl_defs.vh: FSM state encodings, CMD_LOW=0/CMD_HIGH=1 constants.
//  Instantiate mux_2x1_comb as the data selector: i_valid=grant bits, i_en=o_mux_en,
//   i_cmd=o_mux_cmd; its output feeds the output register.
//  No other sub-modules; FSM, counter and output stage local.
// TESTING
//  1 Reset: assert rst 2 cycles with i_valid=2'b11 -> o_valid=0, o_ready=00, o_data_bus=0, o_last_grant=1.
//  2 Lone low: i_valid=01, data_lo=0xA5A5_0001, i_ready=1 -> o_ready=01; next cycle o_valid=1, data=0xA5A5_0001.
//  3 Contention, MAX_BURST=4, first grant high: both valid 12 cycles, i_ready=1 -> grants HHHH LLLL HHHH.
//  4 Backpressure: o_valid=1, i_ready=0 for 3 cycles -> o_ready=00, o_data_bus stable; i_ready=1 resumes.
//  5 Lone high stream 10 flits, i_valid=10 -> 10 consecutive high grants, no cap; o_mux_cmd=1 throughout.
//  6 i_en=0 mid-burst (cnt=2) for 2 cycles -> o_ready=00, output drains, burst resumes at cnt=2 on re-enable.

Source files
------------

// File: rtl/mux_2x1_rr_arbiter_pkg.sv
// ============================================================================
// Module  : mux_2x1_rr_arbiter_pkg
// Brief   : Shared FSM encodings and mux command constants for the 2:1 merge arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_2x1_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD_LO = 2'd1,
        ST_HOLD_HI = 2'd2
    } state_t;

    localparam logic CMD_LOW  = 1'b0;
    localparam logic CMD_HIGH = 1'b1;

    // One-hot grant vector for a single branch index.
    function automatic logic [1:0] branch_onehot(input logic branch);
        return (branch == CMD_HIGH) ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_2x1_comb.sv
// ============================================================================
// Module  : mux_2x1_comb
// Brief   : Combinational 2:1 flit selector; drives zero unless enabled on a valid branch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2x1_comb
    import mux_2x1_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 1
) (
    input  logic [1:0]              i_valid,
    input  logic                    i_en,
    input  logic [COMMAND_WIDTH-1:0] i_cmd,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    output logic [DATA_WIDTH-1:0]   o_data
);

    logic sel;

    assign sel = i_cmd[0];

    always_comb begin
        o_data = '0;
        if (i_en && i_valid[sel]) begin
            o_data = (sel == CMD_HIGH) ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : i_data_bus[DATA_WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_2x1_rr_arbiter.sv
// ============================================================================
// Module  : mux_2x1_rr_arbiter
// Brief   : Round-robin 2:1 merge arbiter with bounded burst and 1-entry output stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2x1_rr_arbiter
    import mux_2x1_rr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 1,
    parameter int MAX_BURST     = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [1:0]               i_valid,
    input  logic [2*DATA_WIDTH-1:0]  i_data_bus,
    output logic [1:0]               o_ready,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    input  logic                     i_ready,
    output logic                     o_mux_en,
    output logic [COMMAND_WIDTH-1:0] o_mux_cmd,
    output logic                     o_last_grant
);

    localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(MAX_BURST);

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] burst_cnt;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 next_last;
    logic [1:0]           grant;
    logic                 load;
    logic                 accept;
    logic                 capped;
    logic [DATA_WIDTH-1:0] mux_data;

    // Reset gates load so nothing is handshaken in a reset cycle.
    assign load   = i_en & ~rst & (~o_valid | i_ready);
    assign accept = load & (|grant);
    assign capped = (burst_cnt >= BURST_MAX);

    assign o_ready  = load ? grant : 2'b00;
    assign o_mux_en = accept;

    always_comb begin
        o_mux_cmd    = '0;
        o_mux_cmd[0] = grant[1];
    end

    always_comb begin
        grant = 2'b00;
        case (state)
            ST_HOLD_LO: begin
                if (i_valid[0] && (!capped || !i_valid[1])) grant = 2'b01;
                else if (i_valid[1])                         grant = 2'b10;
            end
            ST_HOLD_HI: begin
                if (i_valid[1] && (!capped || !i_valid[0])) grant = 2'b10;
                else if (i_valid[0])                         grant = 2'b01;
            end
            default: begin
                case (i_valid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = branch_onehot(~o_last_grant);
                    default: grant = 2'b00;
                endcase
            end
        endcase
    end

    always_comb begin
        next_state = state;
        next_cnt   = burst_cnt;
        next_last  = o_last_grant;
        if (accept) begin
            next_state = grant[1] ? ST_HOLD_HI : ST_HOLD_LO;
            next_last  = grant[1];
            if (grant[1] == o_last_grant)
                next_cnt = capped ? BURST_MAX : burst_cnt + 1'b1;
            else
                next_cnt = CNT_WIDTH'(1);
        end else if (i_en && (grant == 2'b00)) begin
            // Nobody requesting: release the hold so a fresh burst starts at 1.
            next_state = ST_IDLE;
            next_cnt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            burst_cnt    <= '0;
            o_last_grant <= 1'b1;
        end else begin
            state        <= next_state;
            burst_cnt    <= next_cnt;
            o_last_grant <= next_last;
        end
    end

    mux_2x1_comb #(
        .DATA_WIDTH    (DATA_WIDTH),
        .COMMAND_WIDTH (COMMAND_WIDTH)
    ) u_mux (
        .i_valid    (grant),
        .i_en       (o_mux_en),
        .i_cmd      (o_mux_cmd),
        .i_data_bus (i_data_bus),
        .o_data     (mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
        end else if (accept) begin
            o_valid    <= 1'b1;
            o_data_bus <= mux_data;
        end else if (o_valid && i_ready) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_2x1_rr_arbiter.sv
// ============================================================================
// Module  : tb_mux_2x1_rr_arbiter
// Brief   : Directed table-driven bench for the 2:1 round-robin merge arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_2x1_rr_arbiter;

    localparam int DW = 32;
    localparam int NV = 38;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    valid;
    logic [2*DW-1:0] data_bus;
    logic [1:0]    o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic          ready;
    logic          o_mux_en;
    logic [0:0]    o_mux_cmd;
    logic          o_last_grant;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic [1:0]  v;
        logic        rdy;
        logic [1:0]  e_ready;
        logic        e_cmd;
        logic        e_muxen;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
    } vec_t;

    vec_t tv [NV];

    always #5 clk = ~clk;

    mux_2x1_rr_arbiter #(
        .DATA_WIDTH    (DW),
        .COMMAND_WIDTH (1),
        .MAX_BURST     (4),
        .CNT_WIDTH     (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_valid      (valid),
        .i_data_bus   (data_bus),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_data_bus   (o_data_bus),
        .i_ready      (ready),
        .o_mux_en     (o_mux_en),
        .o_mux_cmd    (o_mux_cmd),
        .o_last_grant (o_last_grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setv(input int i, input logic e, input logic [1:0] v, input logic r,
                        input logic [1:0] er, input logic ec, input logic em,
                        input logic ev, input logic [31:0] ed, input logic el);
        tv[i] = '{en: e, v: v, rdy: r, e_ready: er, e_cmd: ec, e_muxen: em,
                  e_valid: ev, e_data: ed, e_last: el};
    endtask

    initial begin
        // Lone low, then drain.
        setv( 0, 1, 2'b00, 1, 2'b00, 0, 0, 0, 32'h0,         1);
        setv( 1, 1, 2'b01, 1, 2'b01, 0, 1, 0, 32'h0,         1);
        setv( 2, 1, 2'b00, 1, 2'b00, 0, 0, 1, 32'hA5A5_0001, 0);
        // Contention: HHHH LLLL HHHH.
        setv( 3, 1, 2'b11, 1, 2'b10, 1, 1, 0, 32'h0,         0);
        setv( 4, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'h5A5A_0003, 1);
        setv( 5, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'h5A5A_0004, 1);
        setv( 6, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'h5A5A_0005, 1);
        setv( 7, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'h5A5A_0006, 1);
        setv( 8, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'hA5A5_0007, 0);
        setv( 9, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'hA5A5_0008, 0);
        setv(10, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'hA5A5_0009, 0);
        setv(11, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'hA5A5_000A, 0);
        setv(12, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'h5A5A_000B, 1);
        setv(13, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'h5A5A_000C, 1);
        setv(14, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'h5A5A_000D, 1);
        // Backpressure: output held, nothing accepted.
        setv(15, 1, 2'b11, 0, 2'b00, 0, 0, 1, 32'h5A5A_000E, 1);
        setv(16, 1, 2'b11, 0, 2'b00, 0, 0, 1, 32'h5A5A_000E, 1);
        setv(17, 1, 2'b11, 0, 2'b00, 0, 0, 1, 32'h5A5A_000E, 1);
        setv(18, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'h5A5A_000E, 1);
        setv(19, 1, 2'b00, 1, 2'b00, 0, 0, 1, 32'hA5A5_0012, 0);
        // Lone high stream of 10: no burst cap.
        setv(20, 1, 2'b10, 1, 2'b10, 1, 1, 0, 32'h0,         0);
        for (int k = 21; k <= 29; k++)
            setv(k, 1, 2'b10, 1, 2'b10, 1, 1, 1, 32'h5A5A_0000 | 32'(k - 1), 1);
        // Disable mid-burst at cnt=2, then resume.
        setv(30, 1, 2'b00, 1, 2'b00, 0, 0, 1, 32'h5A5A_001D, 1);
        setv(31, 1, 2'b11, 1, 2'b01, 0, 1, 0, 32'h0,         1);
        setv(32, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'hA5A5_001F, 0);
        setv(33, 0, 2'b11, 1, 2'b00, 0, 0, 1, 32'hA5A5_0020, 0);
        setv(34, 0, 2'b11, 1, 2'b00, 0, 0, 0, 32'h0,         0);
        setv(35, 1, 2'b11, 1, 2'b01, 0, 1, 0, 32'h0,         0);
        setv(36, 1, 2'b11, 1, 2'b01, 0, 1, 1, 32'hA5A5_0023, 0);
        setv(37, 1, 2'b11, 1, 2'b10, 1, 1, 1, 32'hA5A5_0024, 0);

        rst = 1'b1; en = 1'b1; valid = 2'b11; ready = 1'b1;
        data_bus = {32'h5A5A_FFFF, 32'hA5A5_FFFF};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ready", 64'(o_ready), 64'(2'b00));
            chk("rst_valid", 64'(o_valid), 64'(1'b0));
            chk("rst_data",  64'(o_data_bus), 64'(0));
            chk("rst_last",  64'(o_last_grant), 64'(1'b1));
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst      = 1'b0;
            en       = tv[i].en;
            valid    = tv[i].v;
            ready    = tv[i].rdy;
            data_bus = {32'h5A5A_0000 | 32'(i), 32'hA5A5_0000 | 32'(i)};
            #2;
            chk($sformatf("v%0d_ready", i), 64'(o_ready), 64'(tv[i].e_ready));
            chk($sformatf("v%0d_mux", i), 64'({o_mux_en, o_mux_cmd}),
                64'({tv[i].e_muxen, tv[i].e_cmd}));
            chk($sformatf("v%0d_out", i), 64'({o_valid, o_data_bus}),
                64'({tv[i].e_valid, tv[i].e_data}));
            chk($sformatf("v%0d_last", i), 64'(o_last_grant), 64'(tv[i].e_last));
        end

        // Reset while a high flit sits in the output stage.
        @(negedge clk);
        chk("pre_rst_valid", 64'({o_valid, o_data_bus}), 64'({1'b1, 32'h5A5A_0025}));
        rst = 1'b1; valid = 2'b11; ready = 1'b0; en = 1'b1;
        #2;
        chk("in_rst_ready", 64'(o_ready), 64'(2'b00));
        chk("in_rst_muxen", 64'(o_mux_en), 64'(1'b0));
        @(negedge clk);
        chk("post_rst_out", 64'({o_valid, o_data_bus}), 64'(0));
        chk("post_rst_last", 64'(o_last_grant), 64'(1'b1));
        rst = 1'b0; valid = 2'b11; ready = 1'b1;
        #2;
        chk("post_rst_lowfirst", 64'(o_ready), 64'(2'b01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
